// File: rtl/color_crasher_pkg.sv
// rtl/color_crasher_pkg.sv - shared playfield types, grid constants and DDaver cell test
package color_crasher_pkg;

    typedef logic [11:0] color_t;
    typedef logic [3:0]  cell_t;

    localparam int GRID_COLS      = 16;
    localparam int GRID_ROWS      = 12;
    localparam int BSIZE          = 40;
    localparam int DDAVER_ROWS    = 5;
    localparam int DDAVER_COLS    = 6;
    localparam int DDAVER_MIN_COL = 4;

    // DDavers sit on odd rows and even columns from DDAVER_MIN_COL; col is 5 bits so 16 stays distinct
    function automatic logic is_ddaver_cell(input cell_t row, input logic [4:0] col);
        logic [4:0] dcol;
        logic [3:0] drow;
        dcol = (col >> 1) - 5'd2;
        drow = row >> 1;
        return row[0] && !col[0] && (col >= 5'(DDAVER_MIN_COL)) &&
               (dcol < 5'(DDAVER_COLS)) && (drow < 4'(DDAVER_ROWS));
    endfunction

endpackage

// File: rtl/bullet_bill_scheduler_if.sv
// rtl/bullet_bill_scheduler_if.sv - fire request/response handshake between game logic and scheduler
interface bullet_bill_scheduler_if;
    import color_crasher_pkg::*;

    logic   fire_req;
    color_t fire_color;
    cell_t  blockieee;
    logic   fire_ack;
    logic   fire_nack;

    modport master (output fire_req, fire_color, blockieee, input fire_ack, fire_nack);
    modport slave  (input fire_req, fire_color, blockieee, output fire_ack, fire_nack);

endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running movement tick divider, frozen while en is low
module tick_divider #(
    parameter int MOVE_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(MOVE_DIV - 1));
    assign tick   = en && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bullet_bill_scheduler.sv
// rtl/bullet_bill_scheduler.sv - bullet slot allocation, per-tick movement sweep and DDaver hit detection
module bullet_bill_scheduler
    import color_crasher_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int GRID_COLS   = 16,
    parameter int GRID_ROWS   = 12,
    parameter int FIRE_COL    = 2,
    parameter int MOVE_DIV    = 12_500_000
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            run,
    bullet_bill_scheduler_if.slave                          fire,
    input  logic [DDAVER_ROWS-1:0][DDAVER_COLS-1:0][11:0]   ddavers,
    output logic [NUM_BULLETS-1:0][11:0]                    bullet_color,
    output logic [NUM_BULLETS-1:0][3:0]                     bullet_x,
    output logic [NUM_BULLETS-1:0][3:0]                     bullet_y,
    output logic                                            hit_valid,
    output logic [2:0]                                      hit_row,
    output logic [2:0]                                      hit_col,
    output logic                                            busy
);
    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_STEP = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic                         tick_pend_q, tick_pend_d;
    logic                         armed_q, armed_d;
    logic [NUM_BULLETS-1:0][11:0] col_q, col_d;
    logic [NUM_BULLETS-1:0][3:0]  x_q, x_d;
    logic [NUM_BULLETS-1:0][3:0]  y_q, y_d;

    logic          tick;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [4:0]    nx;
    cell_t         cy;
    logic [2:0]    dcol;
    logic          hit_cand;
    logic          ack, nack, hit;

    tick_divider #(.MOVE_DIV(MOVE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (tick)
    );

    // Lowest-numbered free slot wins allocation
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (col_q[i] == '0) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign nx       = {1'b0, x_q[idx_q]} + 5'd1;
    assign cy       = y_q[idx_q];
    assign dcol     = 3'(nx[4:1] - 4'd2);
    assign hit_cand = is_ddaver_cell(cy, nx) && (ddavers[cy[3:1]][dcol] != '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        armed_d     = armed_q;
        col_d       = col_q;
        x_d         = x_q;
        y_d         = y_q;
        ack         = 1'b0;
        nack        = 1'b0;
        hit         = 1'b0;

        if (!fire.fire_req) armed_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tick || tick_pend_q) begin
                    state_d     = S_STEP;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end else if (armed_q && fire.fire_req) begin
                    armed_d = 1'b0;
                    if (!run || fire.fire_color == '0 ||
                        {1'b0, fire.blockieee} >= 5'(GRID_ROWS) || !free_found) begin
                        nack = 1'b1;
                    end else begin
                        ack             = 1'b1;
                        col_d[free_idx] = fire.fire_color;
                        x_d[free_idx]   = 4'(FIRE_COL);
                        y_d[free_idx]   = fire.blockieee;
                    end
                end
            end
            default: begin
                if (tick) tick_pend_d = 1'b1;
                if (col_q[idx_q] != '0) begin
                    if (nx == 5'(GRID_COLS) || hit_cand) begin
                        hit          = (nx != 5'(GRID_COLS));
                        col_d[idx_q] = '0;
                        x_d[idx_q]   = '0;
                        y_d[idx_q]   = '0;
                    end else begin
                        x_d[idx_q] = nx[3:0];
                    end
                end
                if (idx_q == IW'(NUM_BULLETS - 1)) state_d = S_IDLE;
                else                               idx_d   = idx_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            armed_q     <= 1'b1;
            col_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_pend_q <= tick_pend_d;
            armed_q     <= armed_d;
            col_q       <= col_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    // Pulses are decided combinationally; masking with rst keeps them quiet during a mid-sweep reset
    assign fire.fire_ack  = ack && !rst;
    assign fire.fire_nack = nack && !rst;
    assign hit_valid      = hit && !rst;
    assign hit_row        = cy[3:1];
    assign hit_col        = dcol;
    assign busy           = (state_q == S_STEP);
    assign bullet_color   = col_q;
    assign bullet_x       = x_q;
    assign bullet_y       = y_q;

endmodule
